// File: rtl/gcd_job_controller.sv
// gcd_job_controller
//   Control/status slave that runs one GCD job at a time. It launches the
//   core, waits for the core's done level to rise, enforces a cycle timeout,
//   and recovers the core through its soft reset after a timeout, an abort
//   or a software-requested reset.
//
// Ports
//   CLK, RESETn          clock; asynchronous active-low reset
//   SRAM_CEn/WEn         bus strobe (active-low) and direction (0 = write)
//   SRAM_ADDR[31:0]      byte address, register select in [5:3]
//   SRAM_WDATA[63:0]     write data, SRAM_WBEn[7:0] active-low byte enables
//   SRAM_RDATA[63:0]     registered read data, updated one edge after a read
//   GCD_DONE             core done level
//   GCD_START            one-cycle launch pulse to the core
//   GCD_RSTn             core soft reset, active-low
//   ARGS_LOCK            high while a job is in flight
//   IRQ                  level interrupt on any job-end sticky when enabled
//
// Register map (ADDR[5:3])
//   0 CTRL      bit0 START, bit1 ABORT, bit3 SOFT_RST (write-1 pulses),
//               bit2 IRQ_EN (R/W)
//   1 STATUS    bit0 BUSY, bit1 DONE_S, bit2 TO_S, bit3 ABT_S, bit4 START_ERR
//               (bits 1-4 write-1-to-clear), bits[10:8] FSM state
//   2 TIMEOUT   [31:0] R/W, 0 disables the timeout
//   3 CYCLES    [31:0] RO, length of the last job
//   4 JOB_COUNT [15:0] RO, completed jobs

`timescale 1ns/1ps

module gcd_job_controller #(
  parameter logic [31:0] TIMEOUT_DEFAULT = 32'd100000,
  parameter int          RST_CYCLES      = 4
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        SRAM_CEn,
  input  logic [31:0] SRAM_ADDR,
  input  logic [63:0] SRAM_WDATA,
  input  logic        SRAM_WEn,
  input  logic [7:0]  SRAM_WBEn,
  output logic [63:0] SRAM_RDATA,
  input  logic        GCD_DONE,
  output logic        GCD_START,
  output logic        GCD_RSTn,
  output logic        ARGS_LOCK,
  output logic        IRQ
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LAUNCH   = 3'd1,
    ST_RUN      = 3'd2,
    ST_COMPLETE = 3'd3,
    ST_RECOVER  = 3'd4
  } state_t;

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

  // ------------------------------------------------------------------
  // Bus decode
  // ------------------------------------------------------------------
  logic       bus_wr;
  logic       bus_rd;
  logic [2:0] reg_idx;
  logic       ctrl_wr;
  logic       status_wr;
  logic       timeout_wr;
  logic       start_req;
  logic       abort_req;
  logic       soft_req;
  logic [3:0] w1c_mask;

  assign bus_wr     = ~SRAM_CEn & ~SRAM_WEn;
  assign bus_rd     = ~SRAM_CEn &  SRAM_WEn;
  assign reg_idx    = SRAM_ADDR[5:3];
  assign ctrl_wr    = bus_wr && (reg_idx == 3'd0) && !SRAM_WBEn[0];
  assign status_wr  = bus_wr && (reg_idx == 3'd1) && !SRAM_WBEn[0];
  assign timeout_wr = bus_wr && (reg_idx == 3'd2);

  assign start_req  = ctrl_wr & SRAM_WDATA[0];
  assign abort_req  = ctrl_wr & SRAM_WDATA[1];
  assign soft_req   = ctrl_wr & SRAM_WDATA[3];
  // {START_ERR, ABT_S, TO_S, DONE_S}
  assign w1c_mask   = status_wr ? SRAM_WDATA[4:1] : 4'b0000;

  logic unused_bits;
  assign unused_bits = ^{SRAM_ADDR[31:6], SRAM_ADDR[2:0], SRAM_WDATA[63:32],
                         SRAM_WBEn[7:4]};

  // ------------------------------------------------------------------
  // State and registers
  // ------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic [31:0]       cyc_reg, cyc_next;
  logic [31:0]       cycles_reg;
  logic [15:0]       job_count_reg;
  logic [31:0]       timeout_reg, timeout_next;
  logic [RST_W-1:0]  rst_cnt_reg;
  logic              irq_en_reg;
  logic              done_s_reg, to_s_reg, abt_s_reg, start_err_reg;
  logic              done_q_reg;
  logic [63:0]       rdata_reg, rdata_next;

  logic done_rise;
  logic busy;
  logic set_done, set_to, set_abt, set_start_err;
  logic capture_cyc;

  assign done_rise = GCD_DONE & ~done_q_reg;
  assign busy      = (state_reg != ST_IDLE);

  // Byte-enabled TIMEOUT update
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_timeout_byte
      assign timeout_next[gi*8 +: 8] = (timeout_wr && !SRAM_WBEn[gi]) ?
                                       SRAM_WDATA[gi*8 +: 8] :
                                       timeout_reg[gi*8 +: 8];
    end
  endgenerate

  // ------------------------------------------------------------------
  // FSM next-state and event decode
  // ------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    set_done      = 1'b0;
    set_to        = 1'b0;
    set_abt       = 1'b0;
    set_start_err = start_req & busy;
    capture_cyc   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // START has priority over SOFT_RST when both arrive together
        if (start_req) begin
          state_next = ST_LAUNCH;
        end else if (soft_req) begin
          state_next  = ST_RECOVER;
          capture_cyc = 1'b1;
        end
      end
      // LAUNCH shares the RUN exits so a core that finishes immediately is
      // still seen as a completion.
      ST_LAUNCH, ST_RUN: begin
        if (done_rise) begin
          state_next = ST_COMPLETE;
        end else if (abort_req || soft_req) begin
          state_next  = ST_RECOVER;
          set_abt     = 1'b1;
          capture_cyc = 1'b1;
        end else if ((timeout_reg != 32'd0) && (cyc_reg == timeout_reg)) begin
          state_next  = ST_RECOVER;
          set_to      = 1'b1;
          capture_cyc = 1'b1;
        end else if (state_reg == ST_LAUNCH) begin
          state_next = ST_RUN;
        end
      end
      ST_COMPLETE: begin
        set_done   = 1'b1;
        state_next = ST_IDLE;
      end
      ST_RECOVER: begin
        if (rst_cnt_reg == RST_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Job cycle counter: cleared while idle, saturating while the job runs
  always_comb begin
    cyc_next = cyc_reg;
    case (state_reg)
      ST_IDLE:           cyc_next = 32'd0;
      ST_LAUNCH, ST_RUN: cyc_next = (cyc_reg == 32'hFFFF_FFFF) ? cyc_reg
                                                               : cyc_reg + 32'd1;
      default:           cyc_next = cyc_reg;
    endcase
  end

  // Read data mux
  always_comb begin
    rdata_next = rdata_reg;
    if (bus_rd) begin
      case (reg_idx)
        3'd0:    rdata_next = {61'd0, irq_en_reg, 2'b00};
        3'd1:    rdata_next = {53'd0, state_reg, 3'b000, start_err_reg,
                               abt_s_reg, to_s_reg, done_s_reg, busy};
        3'd2:    rdata_next = {32'd0, timeout_reg};
        3'd3:    rdata_next = {32'd0, cycles_reg};
        3'd4:    rdata_next = {48'd0, job_count_reg};
        default: rdata_next = 64'd0;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Sequential state
  // ------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_reg     <= ST_IDLE;
      cyc_reg       <= 32'd0;
      cycles_reg    <= 32'd0;
      job_count_reg <= 16'd0;
      timeout_reg   <= TIMEOUT_DEFAULT;
      rst_cnt_reg   <= '0;
      irq_en_reg    <= 1'b0;
      done_s_reg    <= 1'b0;
      to_s_reg      <= 1'b0;
      abt_s_reg     <= 1'b0;
      start_err_reg <= 1'b0;
      done_q_reg    <= 1'b0;
      rdata_reg     <= 64'd0;
    end else begin
      state_reg   <= state_next;
      cyc_reg     <= cyc_next;
      timeout_reg <= timeout_next;
      done_q_reg  <= GCD_DONE;
      rdata_reg   <= rdata_next;

      // RECOVER entry capture sees the pre-increment count; completion
      // captures after the final RUN increment.
      if (capture_cyc)
        cycles_reg <= cyc_reg;
      else if (state_reg == ST_COMPLETE)
        cycles_reg <= cyc_reg;

      if (state_reg == ST_COMPLETE)
        job_count_reg <= job_count_reg + 16'd1;

      if (state_reg == ST_RECOVER)
        rst_cnt_reg <= rst_cnt_reg + 1'b1;
      else
        rst_cnt_reg <= '0;

      if (ctrl_wr)
        irq_en_reg <= SRAM_WDATA[2];

      // Hardware set beats a simultaneous write-1-to-clear
      done_s_reg    <= (done_s_reg    & ~w1c_mask[0]) | set_done;
      to_s_reg      <= (to_s_reg      & ~w1c_mask[1]) | set_to;
      abt_s_reg     <= (abt_s_reg     & ~w1c_mask[2]) | set_abt;
      start_err_reg <= (start_err_reg & ~w1c_mask[3]) | set_start_err;
    end
  end

  // ------------------------------------------------------------------
  // Outputs (decoded from registered state, so they follow reset at once)
  // ------------------------------------------------------------------
  assign SRAM_RDATA = rdata_reg;
  assign GCD_START  = (state_reg == ST_LAUNCH);
  assign GCD_RSTn   = (state_reg != ST_RECOVER);
  assign ARGS_LOCK  = busy;
  assign IRQ        = irq_en_reg & (done_s_reg | to_s_reg | abt_s_reg);

endmodule

// File: doc/gcd_job_controller.md
Name: gcd_job_controller

Overview:
- Control/status slave that sequences one GCD job at a time: launches the core, waits for completion, enforces a timeout, and recovers the core on timeout or abort.
- Sits on the same 64-bit SRAM-style bus as the argument/result unpacker, at its own base.
- Drives the core's start and soft reset, locks argument writes while busy, and raises an interrupt on job end.

Parameters:
- TIMEOUT_DEFAULT, 32'd100000, reset value of the TIMEOUT register; 0 disables the timeout.
- RST_CYCLES, 4, cycles GCD_RSTn is held low during recovery (must be at least 1).

Ports:
- CLK  in  1  clock
- RESETn  in  1  reset; asynchronous, active-low
- SRAM_CEn  in  1  chip enable, active-low
- SRAM_ADDR  in  32  byte address; only [5:3] decoded
- SRAM_WDATA  in  64  write data
- SRAM_WEn  in  1  0 = write, 1 = read
- SRAM_WBEn  in  8  byte write enables, active-low
- SRAM_RDATA  out  64  registered read data
- GCD_DONE  in  1  core done level
- GCD_START  out  1  one-cycle launch pulse
- GCD_RSTn  out  1  core soft reset, active-low
- ARGS_LOCK  out  1  high while busy; the unpacker must drop argument writes
- IRQ  out  1  level interrupt = IRQ_EN & (DONE_S | TO_S | ABT_S)

Behaviour:
- Reset values: SRAM_RDATA=0, GCD_START=0, GCD_RSTn=1, ARGS_LOCK=0, IRQ=0, state IDLE, all counters and stickies 0, TIMEOUT=TIMEOUT_DEFAULT.
- Bus access: cycle with CEn=0 and WEn=0 is a write, honouring byte enables. Cycle with CEn=0 and WEn=1 is a read; RDATA updates on the next edge and holds otherwise.
- Unmapped addresses read 0; writes to them are ignored.
- Register map (ADDR[5:3]):
  - 0 CTRL: bit0 START (write-1 pulse), bit1 ABORT (write-1 pulse), bit2 IRQ_EN (R/W), bit3 SOFT_RST (write-1 pulse); reads return only IRQ_EN.
  - 1 STATUS: bit0 BUSY (RO), bit1 DONE_S, bit2 TO_S, bit3 ABT_S, bit4 START_ERR (bits1-4 write-1-to-clear), bits[6:4+... ] see next; bits[10:8] state encoding (RO).
  - 2 TIMEOUT: [31:0] R/W.
  - 3 CYCLES: [31:0] RO, cycle count of the last job.
  - 4 JOB_COUNT: [15:0] RO, completed jobs; wraps at 16 bits.
- done_rise = GCD_DONE & ~done_q, where done_q is GCD_DONE registered every cycle.
- FSM states:
  - IDLE(0): START write -> LAUNCH. Clear cyc to 0.
  - LAUNCH(1): GCD_START=1 for exactly this cycle; cyc increments; -> RUN.
  - RUN(2): cyc increments, saturating at 32'hFFFFFFFF. Exits in priority order:
    - done_rise -> COMPLETE;
    - abort -> RECOVER, set ABT_S;
    - TIMEOUT!=0 and cyc==TIMEOUT -> RECOVER, set TO_S.
  - COMPLETE(3): CYCLES<=cyc, JOB_COUNT+1, set DONE_S -> IDLE.
  - RECOVER(4): GCD_RSTn=0 for RST_CYCLES cycles; on entry CYCLES<=cyc -> IDLE.
- BUSY = ARGS_LOCK = (state != IDLE).
- A done_rise seen in LAUNCH is treated as in RUN: the core finished immediately.
- START while busy: ignored, sets START_ERR.
- ABORT in IDLE: no effect. START and ABORT in the same write while idle: job launches, ABORT ignored.
- SOFT_RST in IDLE -> RECOVER with no sticky set; while busy it behaves as ABORT.
- A hardware set and a W1C of the same sticky in the same cycle: the set wins.
- A TIMEOUT write mid-job takes effect immediately, compared against the current cyc.
- Async reset mid-job: everything returns to reset values at once; GCD_RSTn returns to 1.

Test Plan:
- Reset, then read STATUS -> RDATA=0 one cycle after the read. Read TIMEOUT -> 100000.
- Write CTRL=0x5 (IRQ_EN, START):
  - GCD_START is high exactly 1 cycle and ARGS_LOCK goes high.
  - Drive GCD_DONE high 10 cycles after the GCD_START pulse -> CYCLES=11, JOB_COUNT=1, STATUS=0x2, IRQ=1.
  - Write STATUS=0x2 -> IRQ=0.
- TIMEOUT=5, START with GCD_DONE held low:
  - After cyc==5, GCD_RSTn is low exactly 4 cycles.
  - STATUS.TO_S=1, CYCLES=5, JOB_COUNT unchanged.
- Previous job leaves GCD_DONE high, then START:
  - Stale level is not treated as completion.
  - Drop DONE for 3 cycles, then raise it -> completes, JOB_COUNT increments once.
- While in RUN:
  - Write START -> START_ERR=1, no second GCD_START.
  - Write ABORT in the same cycle GCD_DONE rises -> COMPLETE (DONE_S=1, ABT_S=0).
- TIMEOUT=3 with done_rise landing on cyc==3 -> completion wins, TO_S=0.
- Deassert RESETn during RECOVER -> GCD_RSTn=1 and state IDLE immediately, no clock needed.
